// File: rtl/adc_pkg.sv
// adc_pkg: shared FSM encoding, error codes and channel count for the ADC sample sequencer
package adc_pkg;

    localparam int adcChannels = 8;

    typedef enum logic [3:0] {
        stIdle     = 4'd0,
        stWaitTick = 4'd1,
        stConvst   = 4'd2,
        stWaitBusy = 4'd3,
        stWaitDone = 4'd4,
        stCapture  = 4'd5,
        stWrite    = 4'd6,
        stWaitPkt  = 4'd7,
        stError    = 4'd8
    } seqState_t;

    typedef enum logic [1:0] {
        errNone    = 2'b00,
        errOverrun = 2'b01,
        errTimeout = 2'b10,
        errFull    = 2'b11
    } errCode_t;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous level
module sync_2ff (
    input  logic iClk,
    input  logic iRstN,
    input  logic iD,
    output logic oQ
);

    logic meta;

    // move the asynchronous level through two flops before any logic looks at it
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            meta <= 1'b0;
            oQ   <= 1'b0;
        end else begin
            meta <= iD;
            oQ   <= meta;
        end
    end

endmodule

// File: rtl/adc_sample_sequencer.sv
// adc_sample_sequencer: paces 8-channel ADC conversions and hands each sample to the packetizer
module adc_sample_sequencer
    import adc_pkg::*;
#(
    parameter int pAdcDataWidth     = 16,
    parameter int pSamplesPerPacket = 15,
    parameter int pConvstWidth      = 4,
    parameter int pConvTimeout      = 1023
) (
    input  logic                                 iClk,
    input  logic                                 iRstN,
    input  logic                                 iEnable,
    input  logic [15:0]                          iSampleDiv,
    output logic                                 oAdcConvst,
    input  logic                                 iAdcBusy,
    input  logic [adcChannels*pAdcDataWidth-1:0] iAdcData,
    output logic                                 oSampleWr,
    output logic [adcChannels*pAdcDataWidth-1:0] oSampleData,
    input  logic                                 iPacketWr,
    input  logic                                 iPacketFull,
    output logic                                 oErr,
    output logic [1:0]                           oErrCode,
    output logic                                 oBusy
);

    localparam int                 toWidth     = $clog2(pConvTimeout + 1);
    localparam logic [toWidth-1:0] convstLast  = toWidth'(pConvstWidth - 1);
    localparam logic [toWidth-1:0] timeoutLast = toWidth'(pConvTimeout - 1);
    localparam logic [4:0]         packetLen   = 5'(pSamplesPerPacket);

    seqState_t          state;
    seqState_t          stateNext;
    errCode_t           errCode;
    errCode_t           errNext;
    logic [15:0]        tickCnt;
    logic               tick;
    logic               busySync;
    logic               armed;
    logic [toWidth-1:0] convCnt;
    logic [3:0]         sampleCnt;
    logic               inConv;
    logic               packetDone;
    logic               timeoutHit;
    logic               overrunHit;
    logic               fullHit;
    logic               sampleClr;

    sync_2ff uBusySync (
        .iClk  (iClk),
        .iRstN (iRstN),
        .iD    (iAdcBusy),
        .oQ    (busySync)
    );

    assign tick       = iEnable && (tickCnt == iSampleDiv);
    assign inConv     = state inside {stConvst, stWaitBusy, stWaitDone};
    assign packetDone = ({1'b0, sampleCnt} + 5'd1) == packetLen;
    assign timeoutHit = inConv && (convCnt == timeoutLast);
    assign overrunHit = tick && !(state inside {stIdle, stWaitTick, stError});
    assign fullHit    = (state == stWrite) && packetDone && iPacketFull;
    assign sampleClr  = ((state == stWaitPkt) && iPacketWr) || ((state == stError) && !iEnable);

    assign oAdcConvst = state == stConvst;
    assign oSampleWr  = state == stWrite;
    assign oErr       = state == stError;
    assign oErrCode   = errCode;
    assign oBusy      = !(state inside {stIdle, stError});

    // sample-period pacing; parked at zero whenever the run request is low
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) tickCnt <= '0;
        else        tickCnt <= (!iEnable || tick) ? '0 : tickCnt + 16'd1;
    end

    // sequencing decisions; error sources override the normal flow, timeout first
    always_comb begin
        stateNext = state;
        errNext   = errCode;
        case (state)
            stIdle:     if (armed && iEnable) stateNext = stWaitTick;
            stWaitTick: stateNext = !iEnable ? stIdle : (tick ? stConvst : stWaitTick);
            stConvst:   if (convCnt == convstLast) stateNext = stWaitBusy;
            stWaitBusy: if (busySync) stateNext = stWaitDone;
            stWaitDone: if (!busySync) stateNext = stCapture;
            stCapture:  stateNext = stWrite;
            stWrite:    stateNext = packetDone ? stWaitPkt : stWaitTick;
            stWaitPkt:  if (iPacketWr) stateNext = stWaitTick;
            stError: begin
                if (!iEnable) begin
                    stateNext = stIdle;
                    errNext   = errNone;
                end
            end
            default:    stateNext = stIdle;
        endcase
        if (timeoutHit) begin
            stateNext = stError;
            errNext   = errTimeout;
        end else if (overrunHit) begin
            stateNext = stError;
            errNext   = errOverrun;
        end else if (fullHit) begin
            stateNext = stError;
            errNext   = errFull;
        end
    end

    // state, sticky error code, conversion timer, packet position and captured sample
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state       <= stIdle;
            errCode     <= errNone;
            armed       <= 1'b0;
            convCnt     <= '0;
            sampleCnt   <= '0;
            oSampleData <= '0;
        end else begin
            state       <= stateNext;
            errCode     <= errNext;
            armed       <= 1'b1;
            convCnt     <= (stateNext == stConvst && state != stConvst) ? '0 :
                           inConv ? convCnt + toWidth'(1) : convCnt;
            sampleCnt   <= sampleClr ? '0 : (state == stWrite) ? sampleCnt + 4'd1 : sampleCnt;
            oSampleData <= (state == stCapture) ? iAdcData : oSampleData;
        end
    end

endmodule
